// File: rtl/irq_pkg.sv
// Shared interrupt constants and index/width helpers used by the tile interrupt
// front end and the Dock interrupt router.
package irq_pkg;

    localparam int NUM_SLOTS_DEF       = 5;
    localparam int NUM_TILE_INT_CH_DEF = 2;

    // Flat bit position of a maskable INT channel within the per-slot vectors.
    function automatic int int_idx(input int slot, input int ch, input int num_ch);
        return slot * num_ch + ch;
    endfunction

    // Width of a down/up counter that must hold values 0..max_val (never zero width).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/irq_line_filter.sv
// One interrupt line: multi-flop synchroniser for an active-low async pin followed by
// a consecutive-cycle deglitch filter. f_nxt is the filter's next state so the caller
// can register its outputs in the same stage as the filter.
module irq_line_filter
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_n,
    output logic f_nxt
);

    localparam int CW = cnt_width(FILTER_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s;
    logic                   f_q, f_d;
    logic [CW-1:0]          cnt_q, cnt_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin_n};
        s      = ~sync_q[SYNC_STAGES-1];
        f_d    = f_q;
        cnt_d  = '0;
        if (FILTER_CYCLES == 0) begin
            f_d = s;
        end else if (s != f_q) begin
            // The cycle that completes the stable run flips f; the counter restarts at 0.
            if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
                f_d = s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            f_q    <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            f_q    <= f_d;
            cnt_q  <= cnt_d;
        end
    end

    assign f_nxt = f_d;

endmodule

// File: rtl/irq_input_conditioner.sv
// Dock-side tile interrupt front end: sync + deglitch every INT/NMI pin, gate by slot
// presence, stretch NMI pulses. Optional sticky status under `define IRQ_INPUT_STATUS_EN.
module irq_input_conditioner
    import irq_pkg::*;
#(
    parameter int NUM_SLOTS       = NUM_SLOTS_DEF,
    parameter int NUM_TILE_INT_CH = NUM_TILE_INT_CH_DEF,
    parameter int SYNC_STAGES     = 2,
    parameter int FILTER_CYCLES   = 4,
    parameter int NMI_HOLD_CYCLES = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_SLOTS*NUM_TILE_INT_CH-1:0] tile_int_n,
    input  logic [NUM_SLOTS-1:0]                 tile_nmi_n,
    input  logic [NUM_SLOTS-1:0]                 slot_present,
`ifdef IRQ_INPUT_STATUS_EN
    input  logic [NUM_SLOTS-1:0]                 status_clr,
    output logic [NUM_SLOTS*NUM_TILE_INT_CH-1:0] int_seen,
    output logic [NUM_SLOTS-1:0]                 nmi_seen,
`endif
    output logic [NUM_SLOTS*NUM_TILE_INT_CH-1:0] tile_int_req,
    output logic [NUM_SLOTS-1:0]                 tile_nmi_req
);

    localparam int NI = NUM_SLOTS * NUM_TILE_INT_CH;
    localparam int HW = cnt_width(NMI_HOLD_CYCLES - 1);

    logic [NI-1:0]        f_int_nxt;
    logic [NUM_SLOTS-1:0] f_nmi_nxt;

    logic [NI-1:0]        int_req_q, int_req_d;
    logic [NUM_SLOTS-1:0] nmi_req_q, nmi_req_d;
    logic [NUM_SLOTS-1:0] nmi_qual_q, nmi_qual_d;
    logic [NUM_SLOTS-1:0] nmi_edge;
    logic [HW-1:0]        hold_q [NUM_SLOTS];
    logic [HW-1:0]        hold_d [NUM_SLOTS];

    genvar gs, gc;
    generate
        for (gs = 0; gs < NUM_SLOTS; gs++) begin : g_slot
            for (gc = 0; gc < NUM_TILE_INT_CH; gc++) begin : g_int
                localparam int IDX = int_idx(gs, gc, NUM_TILE_INT_CH);
                irq_line_filter #(
                    .SYNC_STAGES  (SYNC_STAGES),
                    .FILTER_CYCLES(FILTER_CYCLES)
                ) u_int_filt (
                    .clk  (clk),
                    .rst_n(rst_n),
                    .pin_n(tile_int_n[IDX]),
                    .f_nxt(f_int_nxt[IDX])
                );
            end
            irq_line_filter #(
                .SYNC_STAGES  (SYNC_STAGES),
                .FILTER_CYCLES(FILTER_CYCLES)
            ) u_nmi_filt (
                .clk  (clk),
                .rst_n(rst_n),
                .pin_n(tile_nmi_n[gs]),
                .f_nxt(f_nmi_nxt[gs])
            );
        end
    endgenerate

    always_comb begin
        int_req_d  = '0;
        nmi_req_d  = '0;
        nmi_qual_d = f_nmi_nxt & slot_present;
        nmi_edge   = nmi_qual_d & ~nmi_qual_q;
        hold_d     = hold_q;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            for (int c = 0; c < NUM_TILE_INT_CH; c++) begin
                int_req_d[int_idx(s, c, NUM_TILE_INT_CH)] =
                    f_int_nxt[int_idx(s, c, NUM_TILE_INT_CH)] & slot_present[s];
            end
            // Reload beats both expiry and the absent-slot clear.
            if (nmi_edge[s]) begin
                hold_d[s] = HW'(NMI_HOLD_CYCLES - 1);
            end else if (!slot_present[s]) begin
                hold_d[s] = '0;
            end else if (hold_q[s] != '0) begin
                hold_d[s] = hold_q[s] - 1'b1;
            end
            nmi_req_d[s] = slot_present[s] & (nmi_qual_d[s] | (hold_q[s] != '0));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_req_q  <= '0;
            nmi_req_q  <= '0;
            nmi_qual_q <= '0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                hold_q[s] <= '0;
            end
        end else begin
            int_req_q  <= int_req_d;
            nmi_req_q  <= nmi_req_d;
            nmi_qual_q <= nmi_qual_d;
            hold_q     <= hold_d;
        end
    end

    assign tile_int_req = int_req_q;
    assign tile_nmi_req = nmi_req_q;

`ifdef IRQ_INPUT_STATUS_EN
    logic [NI-1:0]        int_clr;
    logic [NI-1:0]        int_seen_q, int_seen_d;
    logic [NUM_SLOTS-1:0] nmi_seen_q, nmi_seen_d;

    // Sticky bits catch the output 0->1 transition; a same-cycle set beats the clear.
    always_comb begin
        int_clr = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            for (int c = 0; c < NUM_TILE_INT_CH; c++) begin
                int_clr[int_idx(s, c, NUM_TILE_INT_CH)] = status_clr[s];
            end
        end
        int_seen_d = (int_seen_q & ~int_clr) | (int_req_d & ~int_req_q);
        nmi_seen_d = (nmi_seen_q & ~status_clr) | (nmi_req_d & ~nmi_req_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_seen_q <= '0;
            nmi_seen_q <= '0;
        end else begin
            int_seen_q <= int_seen_d;
            nmi_seen_q <= nmi_seen_d;
        end
    end

    assign int_seen = int_seen_q;
    assign nmi_seen = nmi_seen_q;
`endif

endmodule

// File: tb/tb_irq_input_conditioner.sv
// Bench for irq_input_conditioner: directed scenarios plus random pin/presence traffic,
// all checked every cycle against a pin-history reference model.
module tb_irq_input_conditioner;

    localparam int NS   = 5;
    localparam int NC   = 2;
    localparam int NI   = NS * NC;
    localparam int NP   = NI + NS;
    localparam int SYNC = 2;
    localparam int FC   = 4;
    localparam int HOLD = 16;
    localparam int MAXC = 1024;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NI-1:0] tile_int_n   = '1;
    logic [NS-1:0] tile_nmi_n   = '1;
    logic [NS-1:0] slot_present = '0;
    logic [NS-1:0] status_clr   = '0;
    logic [NI-1:0] tile_int_req;
    logic [NS-1:0] tile_nmi_req;
`ifdef IRQ_INPUT_STATUS_EN
    logic [NI-1:0] int_seen;
    logic [NS-1:0] nmi_seen;
`endif

    irq_input_conditioner dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tile_int_n  (tile_int_n),
        .tile_nmi_n  (tile_nmi_n),
        .slot_present(slot_present),
`ifdef IRQ_INPUT_STATUS_EN
        .status_clr  (status_clr),
        .int_seen    (int_seen),
        .nmi_seen    (nmi_seen),
`endif
        .tile_int_req(tile_int_req),
        .tile_nmi_req(tile_nmi_req)
    );

    always #5 clk = ~clk;

    // Input history (raw pins {nmi,int}, presence, clear) and model state, indexed by
    // cycle number since the last reset release.
    logic [NP-1:0] h_pin  [MAXC];
    logic [NS-1:0] h_pres [MAXC];
    logic [NS-1:0] h_clr  [MAXC];
    logic [NP-1:0] m_f    [MAXC];
    logic [NS-1:0] m_qual [MAXC];
    logic [NI-1:0] m_ireq [MAXC];
    logic [NS-1:0] m_nreq [MAXC];
    logic [NI-1:0] m_iseen[MAXC];
    logic [NS-1:0] m_nseen[MAXC];

    int k;
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    // Active-high synchronised level of line i during cycle m.
    function automatic logic s_at(input int m, input int i);
        if (m < SYNC) return 1'b0;
        return ~h_pin[m-SYNC][i];
    endfunction

    task automatic model_step();
        logic [NP-1:0] fo, fn;
        logic [NS-1:0] pv;
        logic          all_diff, r;
        int            j;
        fo = m_f[k-1];
        for (int i = 0; i < NP; i++) begin
            all_diff = 1'b1;
            for (int d = 1; d <= FC; d++) begin
                if (s_at(k - d, i) == fo[i]) all_diff = 1'b0;
            end
            fn[i] = all_diff ? ~fo[i] : fo[i];
        end
        m_f[k] = fn;
        pv = h_pres[k-1];
        for (int s = 0; s < NS; s++) begin
            for (int c = 0; c < NC; c++) begin
                m_ireq[k][s*NC+c] = fn[s*NC+c] & pv[s];
            end
            m_qual[k][s] = fn[NI+s] & pv[s];
        end
        for (int s = 0; s < NS; s++) begin
            r = m_qual[k][s];
            j = k;
            while (j >= 1 && j > k - HOLD && h_pres[j-1][s]) begin
                if (m_qual[j][s] && !m_qual[j-1][s]) r = 1'b1;
                j--;
            end
            m_nreq[k][s] = r;
        end
        for (int s = 0; s < NS; s++) begin
            for (int c = 0; c < NC; c++) begin
                m_iseen[k][s*NC+c] = (m_iseen[k-1][s*NC+c] & ~h_clr[k-1][s]) |
                                     (m_ireq[k][s*NC+c] & ~m_ireq[k-1][s*NC+c]);
            end
            m_nseen[k][s] = (m_nseen[k-1][s] & ~h_clr[k-1][s]) |
                            (m_nreq[k][s] & ~m_nreq[k-1][s]);
        end
    endtask

    task automatic cyc(input logic [NI-1:0] i_int, input logic [NS-1:0] i_nmi,
                       input logic [NS-1:0] i_pres, input logic [NS-1:0] i_clr);
        if (k >= MAXC - 1) begin
            $display("FAIL history_overflow cycle=%0d", k);
            $fatal(1);
        end
        tile_int_n   = i_int;
        tile_nmi_n   = i_nmi;
        slot_present = i_pres;
        status_clr   = i_clr;
        h_pin[k]  = {i_nmi, i_int};
        h_pres[k] = i_pres;
        h_clr[k]  = i_clr;
        @(posedge clk);
        #1;
        k++;
        model_step();
        chk("int_req", 32'(tile_int_req), 32'(m_ireq[k]));
        chk("nmi_req", 32'(tile_nmi_req), 32'(m_nreq[k]));
`ifdef IRQ_INPUT_STATUS_EN
        chk("int_seen", 32'(int_seen), 32'(m_iseen[k]));
        chk("nmi_seen", 32'(nmi_seen), 32'(m_nseen[k]));
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_int_req", 32'(tile_int_req), 32'h0);
        chk("rst_nmi_req", 32'(tile_nmi_req), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        m_f[0] = '0; m_qual[0] = '0; m_ireq[0] = '0; m_nreq[0] = '0;
        m_iseen[0] = '0; m_nseen[0] = '0;
        #1;
        chk("rel_int_req", 32'(tile_int_req), 32'h0);
        chk("rel_nmi_req", 32'(tile_nmi_req), 32'h0);
    endtask

    logic [NI-1:0] r_int;
    logic [NS-1:0] r_nmi, r_pres, r_clr;

    initial begin
        rst_n = 1'b1;
        k = 0;
        #2;

        // Slot 1 channel 1 pulse: rises at 6, falls at 26.
        do_reset();
        for (int t = 0; t < 40; t++) begin
            cyc((t < 20) ? ~NI'(10'h008) : '1, '1, 5'b00010, '0);
            if (k == 5)  chk("t1_before", 32'(tile_int_req), 32'h0);
            if (k == 6)  chk("t1_rise",   32'(tile_int_req), 32'h8);
            if (k == 25) chk("t1_hold",   32'(tile_int_req), 32'h8);
            if (k == 26) chk("t1_fall",   32'(tile_int_req), 32'h0);
        end

        // Two 3-cycle glitches split by one high cycle never qualify.
        do_reset();
        for (int t = 0; t < 20; t++) begin
            cyc((t < 3 || (t >= 4 && t < 7)) ? ~NI'(1) : '1, '1, '1, '0);
            chk("t2_glitch", 32'(tile_int_req), 32'h0);
        end

        // NMI slot 2: two 5-cycle pulses, stretched and reloaded to cover 6..31.
        do_reset();
        for (int t = 0; t < 40; t++) begin
            cyc('1, (t < 5 || (t >= 10 && t < 15)) ? 5'b11011 : '1, '1, '0);
            chk("t3_nmi2", 32'(tile_nmi_req[2]), 32'((k >= 6 && k <= 31) ? 1 : 0));
        end

        // Slot 1 absent with pins held low, then inserted at 30 and removed at 60.
        do_reset();
        for (int t = 0; t < 70; t++) begin
            cyc(~NI'(10'h004), 5'b11101, (t >= 30 && t < 60) ? 5'b11111 : 5'b11101, '0);
            if (k == 30) chk("t4_absent", 32'({tile_int_req[2], tile_nmi_req[1]}), 32'h0);
            if (k == 31) chk("t4_insert", 32'({tile_int_req[2], tile_nmi_req[1]}), 32'h3);
            if (k == 46) chk("t4_held",   32'(tile_nmi_req[1]), 32'h1);
            if (k == 61) chk("t4_remove", 32'({tile_int_req[2], tile_nmi_req[1]}), 32'h0);
        end

        // Reset during an NMI hold; pin still low afterwards re-qualifies at 6.
        do_reset();
        for (int t = 0; t < 12; t++) cyc('1, 5'b11110, '1, '0);
        chk("t5_active", 32'(tile_nmi_req[0]), 32'h1);
        do_reset();
        for (int t = 0; t < 10; t++) begin
            cyc('1, 5'b11110, '1, '0);
            if (k == 5) chk("t5_quiet", 32'(tile_nmi_req[0]), 32'h0);
            if (k == 6) chk("t5_again", 32'(tile_nmi_req[0]), 32'h1);
        end

`ifdef IRQ_INPUT_STATUS_EN
        // Sticky INT bit 4 (slot 2): persists, clears alone, survives clear on a new edge.
        do_reset();
        for (int t = 0; t < 50; t++) begin
            cyc((t < 10 || t >= 40) ? ~NI'(10'h010) : '1, '1, '1,
                (t == 30 || t == 45) ? 5'b00100 : '0);
            if (k == 30) chk("t6_sticky",  32'(int_seen[4]), 32'h1);
            if (k == 31) chk("t6_cleared", 32'(int_seen[4]), 32'h0);
            if (k == 46) chk("t6_setwins", 32'(int_seen[4]), 32'h1);
        end
`endif

        // Random pin, presence and clear traffic with a reset in the middle.
        do_reset();
        r_int = '1; r_nmi = '1; r_pres = '1;
        for (int t = 0; t < 700; t++) begin
            for (int i = 0; i < NI; i++) if ($urandom_range(0, 9) == 0) r_int[i] = ~r_int[i];
            for (int s = 0; s < NS; s++) if ($urandom_range(0, 11) == 0) r_nmi[s] = ~r_nmi[s];
            for (int s = 0; s < NS; s++) if ($urandom_range(0, 59) == 0) r_pres[s] = ~r_pres[s];
            r_clr = '0;
            for (int s = 0; s < NS; s++) if ($urandom_range(0, 19) == 0) r_clr[s] = 1'b1;
            cyc(r_int, r_nmi, r_pres, r_clr);
            if (t == 350) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_input_conditioner.md
Name: irq_input_conditioner

Overview:
Dock-side front end for tile interrupt pins, directly upstream of the Dock interrupt router.
- Takes the raw active-low, asynchronous tile INT/NMI pins.
- Synchronises them to clk, deglitches each line and gates it by slot occupancy.
- Stretches short NMI pulses.
- Outputs are the active-high level vectors tile_int_req / tile_nmi_req that the router consumes.

Parameters:
NUM_SLOTS, 5, number of tile slots
NUM_TILE_INT_CH, 2, maskable INT channels per slot
SYNC_STAGES, 2, synchroniser flop depth (>=2)
FILTER_CYCLES, 4, consecutive stable cycles required to accept a level change (0 = filter bypass)
NMI_HOLD_CYCLES, 16, minimum asserted width of tile_nmi_req after an NMI edge (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tile_int_n  input  NUM_SLOTS*NUM_TILE_INT_CH  raw maskable INT pins, active-low, async; bit = slot*NUM_TILE_INT_CH+ch
tile_nmi_n  input  NUM_SLOTS  raw NMI pins, active-low, async
slot_present  input  NUM_SLOTS  slot occupied (synchronous to clk)
tile_int_req  output  NUM_SLOTS*NUM_TILE_INT_CH  qualified maskable requests, active-high, registered
tile_nmi_req  output  NUM_SLOTS  qualified NMI requests, active-high, registered

Behaviour:
- Reset (async assert, sync release via rst_n):
  - Synchroniser flops reset to 1 (pin deasserted).
  - Filtered state 0, filter counters 0, NMI hold counters 0.
  - All outputs 0.
  - Reset mid-operation clears everything immediately; lines re-qualify from scratch after release.
- Sync: each pin passes through SYNC_STAGES flops, then is inverted to active-high s.
- Filter, per line:
  - Holds filtered state f and counter cnt of width $clog2(FILTER_CYCLES+1).
  - If s != f: cnt increments. When s has differed from f for FILTER_CYCLES consecutive cycles, f <= s and cnt <= 0.
  - Any cycle with s == f: cnt <= 0.
  - FILTER_CYCLES=0: f <= s every cycle.
- Latency: a pin change held stable reaches f after SYNC_STAGES+FILTER_CYCLES rising edges (6 at defaults). Outputs are driven from the same register stage, so there is no further delay.
- INT output: tile_int_req[i] = f_int[i] & slot_present[slot(i)]. A deasserting pin drops the output with the same latency.
- NMI edge: an NMI edge occurs on a cycle where the next-state value (f_nmi & slot_present) is 1 and the current value was 0. This includes slot_present rising while f_nmi is already 1.
- NMI hold: an edge loads hold <= NMI_HOLD_CYCLES-1. Otherwise hold decrements while nonzero.
- NMI output: tile_nmi_req[s] is 1 from the edge cycle while (f_nmi & present) or hold != 0. Net width is max(NMI_HOLD_CYCLES, qualified level width).
- A new edge during the hold reloads the counter. No underflow; the counter saturates at 0.
- slot_present[s]=0:
  - Forces that slot's outputs to 0 on the next edge and clears its hold counter.
  - Filters keep running, so the current pin level is known on insertion.
  - On presence rising, INT outputs follow f on the next edge.
- Simultaneous events:
  - Filter acceptance and presence fall in the same cycle: output 0.
  - Edge and hold expiry in the same cycle: the reload wins.

Optional Feature:
IRQ_INPUT_STATUS_EN
- Defined: adds input status_clr [NUM_SLOTS] and outputs int_seen [NUM_SLOTS*NUM_TILE_INT_CH] and nmi_seen [NUM_SLOTS].
  - Sticky bits are set on each qualified rising edge (output 0->1) of the matching request.
  - status_clr[s] clears all bits of slot s next cycle; set wins over a same-cycle clear.
  - All bits reset to 0.
- Undefined: ports and flops are absent; behaviour is otherwise identical.

Decomposition:
- Shared package irq_pkg: NUM_SLOTS / NUM_TILE_INT_CH default constants (shared with the router), an int-index helper function (slot*NUM_TILE_INT_CH+ch), and a counter-width function.
- Sub-module irq_line_filter (synchroniser + deglitch counter for one line, outputs f).
  - Instantiated NUM_SLOTS*NUM_TILE_INT_CH + NUM_SLOTS times via generate.
  - Presence gating, NMI stretch and status stay in the top.

Test Plan:
1. slot_present=5'b00010; tile_int_n[3] low at cycle 0, released at cycle 20 -> tile_int_req[3] rises at cycle 6 and falls at cycle 26; other bits stay 0.
2. tile_int_n[0] low for 3 cycles, slot 0 present -> tile_int_req stays 0, and the filter counter returns to 0.
3. tile_nmi_n[2] low for 5 cycles, slot 2 present -> tile_nmi_req[2] high cycles 6..21 (16 cycles). Second 5-cycle pulse starting at cycle 10 -> high cycles 6..(16+16-1)=31 via reload.
4. slot_present[1]=0 with tile_int_n[2] and tile_nmi_n[1] held low -> outputs 0. Set present at cycle 30 -> tile_int_req[2]=1 and tile_nmi_req[1]=1 from cycle 31, NMI held >=16 cycles. Drop present -> both 0 next cycle.
5. Assert rst_n=0 during an NMI hold -> all outputs 0 immediately. Release with pin still low -> tile_nmi_req reasserts 6 cycles after release.
6. IRQ_INPUT_STATUS_EN: pulse tile_int_n[4] long enough to qualify -> int_seen[4]=1 stays after the request drops. status_clr[2] on the same cycle as a new edge -> bit stays 1; clear alone -> 0.
